mem_access_unit: RTL and testbench

//   Load/store front-end for the word-addressed data MEMORY (comb. read, posedge write).

---
 rtl/mem_access_unit.sv | 112 +++++++++++
 tb/tb_mem_access_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-addressed data memory: in-order request queue,
// a three-state issue FSM, and a valid/ready response channel.
module mem_access_unit #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 8,
  parameter int QDEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 mem_write,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [WORD_SIZE-1:0] mem_data_in,
  input  logic [WORD_SIZE-1:0] mem_data_out
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] QD = (PW+1)'(QDEPTH);

  typedef struct packed {
    logic                 we;
    logic [31:0]          addr;
    logic [WORD_SIZE-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  req_t                 q_mem [QDEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          cnt_q;
  state_t               state_q;
  logic                 wk_we_q, wk_err_q;
  logic [ADDR_W-1:0]    wk_idx_q;
  logic [WORD_SIZE-1:0] wk_wdata_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 err_q;

  logic full, empty, push, pop, head_err;
  req_t head;

  assign full      = (cnt_q == QD);
  assign empty     = (cnt_q == '0);
  assign req_ready = rst_n & ~full;
  assign push      = req_valid & req_ready;
  assign pop       = ~empty & ((state_q == IDLE) | ((state_q == RESP) & resp_ready));
  assign head      = q_mem[rd_ptr_q];
  assign head_err  = (head.addr[1:0] != 2'b00) | ((head.addr >> (ADDR_W+2)) != 32'd0);

  // Memory strobes decode the state directly so an async reset kills a write mid-cycle.
  assign mem_write   = (state_q == ACCESS) & wk_we_q & ~wk_err_q;
  assign mem_address = ((state_q == ACCESS) & ~wk_err_q) ? wk_idx_q : '0;
  assign mem_data_in = (state_q == ACCESS) ? wk_wdata_q : '0;
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wk_we_q    <= 1'b0;
      wk_err_q   <= 1'b0;
      wk_idx_q   <= '0;
      wk_wdata_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (pop) begin
        wk_we_q    <= head.we;
        wk_err_q   <= head_err;
        wk_idx_q   <= head.addr[ADDR_W+1:2];
        wk_wdata_q <= head.wdata;
      end
      case (state_q)
        IDLE:   if (pop) state_q <= ACCESS;
        ACCESS: begin
          rdata_q <= (~wk_we_q & ~wk_err_q) ? mem_data_out : '0;
          err_q   <= wk_err_q;
          state_q <= RESP;
        end
        RESP:   if (resp_ready) state_q <= pop ? ACCESS : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: memory model, in-order expected-response queue,
// and literal checks on latency, stall, reset abort and throughput.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_write;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in, mem_data_out;

  mem_access_unit #(.WORD_SIZE(32), .ADDR_W(8), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  assign mem_data_out = mem[mem_address];
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_write) mem[mem_address] <= mem_data_in;
  end

  typedef struct {
    logic        we;
    logic        err;
    logic [7:0]  idx;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl_mem [256];
  int          hs_cyc[$];
  int          nvec = 0, nerr = 0, cyc = 0, nresp = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic        wr_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    if (i == 10) return 32'hFFFF_FFFF;
    if (i == 1)  return 32'hA5A5_A5A5;
    return {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3};
  endfunction

  always @(negedge rst_n) exp_q.delete();

  // Compare process: strobes and responses against the model, then record new acceptances.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_write) begin
        wr_seen = 1'b1;
        if (exp_q.size() == 0) chk("wr_unexpected", 32'(mem_write), 32'd0);
        else begin
          chk("wr_kind", {30'd0, exp_q[0].we, exp_q[0].err}, 32'd2);
          chk("wr_addr", 32'(mem_address), 32'(exp_q[0].idx));
          chk("wr_data", mem_data_in, exp_q[0].wdata);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 32'(resp_valid), 32'd0);
        else begin
          chk("resp_rdata", resp_rdata, exp_q[0].rdata);
          chk("resp_err", 32'(resp_err), 32'(exp_q[0].err));
          if (resp_ready) begin
            last_rdata = resp_rdata;
            last_err   = resp_err;
            hs_cyc.push_back(cyc);
            nresp++;
            void'(exp_q.pop_front());
          end
        end
      end
      if (req_valid && req_ready) begin
        exp_t e;
        e.we    = req_we;
        e.err   = (req_addr % 4 != 0) || (req_addr >= 32'd1024);
        e.idx   = 8'(req_addr / 4);
        e.wdata = req_wdata;
        e.rdata = (!e.we && !e.err) ? mdl_mem[e.idx] : 32'd0;
        if (e.we && !e.err) mdl_mem[e.idx] = e.wdata;
        exp_q.push_back(e);
      end
    end
  end

  task automatic offer(input logic we, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
  endtask

  task automatic wait_acc();
    logic ok;
    int   t;
    t = 0;
    do begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1; t++;
    end while (!ok && t < 200);
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d);
    offer(we, a, d);
    wait_acc();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(posedge clk); #1; t++; end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    #2;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_data_in", mem_data_in, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    for (int i = 0; i < 256; i++) begin
      pre_en = 1'b1; pre_addr = 8'(i); pre_data = pat(i); mdl_mem[i] = pat(i);
      @(posedge clk); #1;
    end
    pre_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // 1: store then load of the same word
    resp_ready = 1'b1;
    send(1'b1, 32'h3C, 32'hDEAD_BEEF);
    send(1'b0, 32'h3C, 32'd0);
    drain();
    chk("t1_mem15", mem[15], 32'hDEAD_BEEF);
    chk("t1_load_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("t1_load_err", 32'(last_err), 32'd0);

    // 2: latency from acceptance to resp_valid
    send(1'b0, 32'h28, 32'd0);
    @(negedge clk); chk("t2_lat_n0", 32'(resp_valid), 32'd0);
    @(negedge clk); chk("t2_lat_n1", 32'(resp_valid), 32'd0);
    @(negedge clk); chk("t2_lat_n2", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    drain();
    chk("t2_rdata", last_rdata, 32'hFFFF_FFFF);
    chk("t2_err", 32'(last_err), 32'd0);

    // 3: misaligned store and out-of-range load
    wr_seen = 1'b0;
    send(1'b1, 32'h3D, 32'hCAFE_F00D);
    send(1'b0, 32'h400, 32'd0);
    drain();
    chk("t3_no_write", 32'(wr_seen), 32'd0);
    chk("t3_mem15", mem[15], 32'hDEAD_BEEF);
    chk("t3_err", 32'(last_err), 32'd1);
    chk("t3_rdata", last_rdata, 32'd0);

    // 4: capacity and stall with the response channel blocked
    resp_ready = 1'b0;
    n0 = nresp;
    send(1'b0, 32'h10, 32'd0);
    send(1'b0, 32'h14, 32'd0);
    send(1'b0, 32'h18, 32'd0);
    offer(1'b0, 32'h1C, 32'd0);
    repeat (3) begin @(negedge clk); chk("t4_stall", 32'(req_ready), 32'd0); end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_acc();
    drain();
    chk("t4_nresp", 32'(nresp - n0), 32'd4);
    chk("t4_last_rdata", last_rdata, {8'h07, 8'hF8, 8'h5D, 8'hC3});

    // 5: async reset during the ACCESS of a store
    send(1'b1, 32'h04, 32'h1234_5678);
    @(posedge clk); #2;
    chk("t5_write_before", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_write_dropped", 32'(mem_write), 32'd0);
    chk("t5_resp_valid", 32'(resp_valid), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("t5_mem1", mem[1], 32'hA5A5_A5A5);
    mdl_mem[1] = 32'hA5A5_A5A5;
    rst_n = 1'b1;
    #1;
    chk("t5_req_ready_after", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_queue_empty", 32'(resp_valid), 32'd0);
    send(1'b0, 32'h04, 32'd0);
    drain();
    chk("t5_load_back", last_rdata, 32'hA5A5_A5A5);

    // 6: throughput with resp_ready held high
    hs_cyc.delete();
    for (int i = 0; i < 8; i++) send(1'b0, 32'(32'h80 + i * 4), 32'd0);
    drain();
    chk("t6_count", 32'(hs_cyc.size()), 32'd8);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("t6_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
